median5_window_buf: RTL and testbench
=====================================

// Module: median5_window_buf
// PURPOSE
//  Upstream feeder for the 5-tap median stage: takes one time-multiplexed sample stream (16 channels interleaved, tagged by channel).
//  Keeps the last 4 samples of every channel and presents 5 consecutive same-channel samples as a window.
//  Registered, 1-cycle latency, with the channel tag carried alongside, so the median stage and downstream keep channel alignment.
// PARAMETERS
//  NCH   16   number of interleaved channels
//  DW    16   sample width, two's-complement signed
//  CHW   4    channel-tag width, = clog2(NCH)
// PORTS
//  CLK        in   1     single clock; all logic on rising edge
//  RST        in   1     synchronous, active-high reset
//  CLR_ALL    in   1     synchronous flush of every channel history (no reset of outputs beyond OUT_VALID)
//  IN_VALID   in   1     DATA_IN/CH_IN valid this cycle (no backpressure; one sample per cycle max)
//  CH_IN      in   CHW   channel index of DATA_IN
//  DATA_IN    in   DW    signed sample
//  OUT_VALID  out  1     window valid (1-cycle pulse per accepted, primed sample)
//  CH_OUT     out  CHW   channel of the window
//  TAP1..TAP5 out  DW    signed window; TAP1 = newest (current DATA_IN), TAP5 = oldest (4 samples back)
//  PRIMING    out  1     pulse: sample accepted but channel not yet primed (window suppressed)
// BEHAVIOUR
//  - Reset (RST=1 at edge): OUT_VALID=0, PRIMING=0, CH_OUT=0, TAP1..5=0, all histories=0, all fill counters=0. RST overrides everything.
//  - Per channel c: history H[c][0..3] (H0 newest) and fill counter F[c] in 0..4, saturating at 4.
//  - Accept: IN_VALID=1 && CH_IN<NCH && !CLR_ALL && !RST.
//  - On accept, at the next edge:
//      H[c] <= {DATA_IN, H0, H1, H2}; F[c] <= min(F[c]+1, 4).
//      TAPn <= {DATA_IN, H0, H1, H2, H3}, using values before the update.
//  - Output qualification:
//      OUT_VALID=1 iff F[c]==4 before the update, so the 5th and later samples of a channel produce windows.
//      PRIMING=1 iff F[c]<4. Exactly one of OUT_VALID/PRIMING pulses per accepted sample.
//  - No accept: OUT_VALID=0, PRIMING=0; TAP/CH_OUT hold their last values.
//  - Latency: DATA_IN at edge k -> TAP1 at edge k+1. Median stage adds 1 more; total 2 from DATA_IN to median.
//  - Back-to-back same channel: the history update is flop-based and visible on the next cycle; no bubbles needed. Any channel order is legal.
//  - CH_IN>=NCH (only possible when NCH is not a power of 2): sample dropped, no state change, no pulses.
//  - CLR_ALL:
//      All H=0, F=0 at the next edge; OUT_VALID=0, PRIMING=0 that cycle.
//      A simultaneous IN_VALID sample is discarded (CLR wins).
//  - Reset mid-stream: identical to power-up; every channel must re-prime with 4 samples.
//  - No arithmetic on data: samples pass bit-exact, sign preserved. F is a 3-bit unsigned saturating counter.
// STRUCTURE
//  - Shared package median5_pkg: DW, NCH, CHW, FILL_W=3, FILL_FULL=3'd4, sample_t (signed [DW-1:0]), window_t (5 x sample_t).
//    The median stage and this block both use it.
//  - Sub-module median5_hist_lane: one channel's 4-deep shift register plus saturating fill counter.
//    Ports: CLK, RST, CLR, SHIFT, D, H0..H3, FULL. Instantiated NCH times via generate.
//  - Top: CH_IN decode -> SHIFT one-hot; NCH:1 mux of lane H0..H3/FULL by CH_IN; output register stage.
// TESTING
//  1. Reset then ch 3 samples 10,20,30,40,50 consecutive
//     -> PRIMING pulses x4; on the 5th, OUT_VALID=1, CH_OUT=3, TAP1..5=50,40,30,20,10.
//  2. Interleave ch0..ch15 round-robin, 6 rounds, sample = ch*100+round
//     -> no OUT_VALID in rounds 0-3; round 4 ch7: TAPs 704,703,702,701,700; round 5: 705..701.
//  3. Signed passthrough on ch 0: -32768, 32767, -1, 0, 1
//     -> TAP1..5 = 1,0,-1,32767,-32768 bit-exact.
//  4. Prime ch 5, assert CLR_ALL with IN_VALID=1 on ch 5
//     -> no pulse that cycle; next 4 ch-5 samples give PRIMING only, 5th gives OUT_VALID with zero-free window.
//  5. RST asserted mid-stream for 1 cycle on a primed channel
//     -> outputs 0 next cycle; channel re-primes (4 PRIMING pulses before OUT_VALID).
//  6. IN_VALID gaps (valid every 3rd cycle) on ch 9
//     -> TAP/CH_OUT hold between pulses; window contents identical to gap-free run.

Source files
------------

// File: rtl/median5_pkg.sv
// rtl/median5_pkg.sv - shared types and constants for the 5-tap median path
package median5_pkg;
  localparam int NCH    = 16;
  localparam int DW     = 16;
  localparam int CHW    = $clog2(NCH);
  localparam int FILL_W = 3;
  localparam logic [FILL_W-1:0] FILL_FULL = 3'd4;

  typedef logic signed [DW-1:0] sample_t;
  // Index 0 is the newest sample of the window, index 4 the oldest.
  typedef sample_t [4:0] window_t;
endpackage

// File: rtl/median5_hist_lane.sv
// rtl/median5_hist_lane.sv - one channel's 4-deep sample history and saturating fill count
module median5_hist_lane
  import median5_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic          SHIFT,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] H0,
  output logic [DW-1:0] H1,
  output logic [DW-1:0] H2,
  output logic [DW-1:0] H3,
  output logic          FULL
);
  sample_t             h_q [4];
  sample_t             h_d [4];
  logic [FILL_W-1:0]   fill_q;
  logic [FILL_W-1:0]   fill_d;

  always_comb begin
    h_d    = h_q;
    fill_d = fill_q;
    if (CLR) begin
      for (int i = 0; i < 4; i++) h_d[i] = '0;
      fill_d = '0;
    end else if (SHIFT) begin
      h_d[0] = D;
      h_d[1] = h_q[0];
      h_d[2] = h_q[1];
      h_d[3] = h_q[2];
      if (fill_q != FILL_FULL) fill_d = fill_q + 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) h_q[i] <= '0;
      fill_q <= '0;
    end else begin
      h_q    <= h_d;
      fill_q <= fill_d;
    end
  end

  assign H0   = h_q[0];
  assign H1   = h_q[1];
  assign H2   = h_q[2];
  assign H3   = h_q[3];
  assign FULL = (fill_q == FILL_FULL);
endmodule

// File: rtl/median5_window_buf.sv
// rtl/median5_window_buf.sv - per-channel history buffer presenting 5-sample windows to the median stage
module median5_window_buf
  import median5_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR_ALL,
  input  logic                 IN_VALID,
  input  logic [CHW-1:0]       CH_IN,
  input  logic signed [DW-1:0] DATA_IN,
  output logic                 OUT_VALID,
  output logic [CHW-1:0]       CH_OUT,
  output logic signed [DW-1:0] TAP1,
  output logic signed [DW-1:0] TAP2,
  output logic signed [DW-1:0] TAP3,
  output logic signed [DW-1:0] TAP4,
  output logic signed [DW-1:0] TAP5,
  output logic                 PRIMING
);
  sample_t        lane_h [NCH][4];
  logic [NCH-1:0] lane_full;
  logic [NCH-1:0] shift;
  logic [31:0]    ch_ext;
  logic           accept;

  logic           out_valid_q, out_valid_d;
  logic           priming_q, priming_d;
  logic [CHW-1:0] ch_out_q, ch_out_d;
  window_t        taps_q, taps_d;

  assign ch_ext = 32'(CH_IN);
  assign accept = IN_VALID && (ch_ext < 32'(NCH)) && !CLR_ALL;

  always_comb begin
    shift = '0;
    for (int i = 0; i < NCH; i++) shift[i] = accept && (ch_ext == 32'(i));
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    median5_hist_lane u_lane (
      .CLK   (CLK),
      .RST   (RST),
      .CLR   (CLR_ALL),
      .SHIFT (shift[g]),
      .D     (DATA_IN),
      .H0    (lane_h[g][0]),
      .H1    (lane_h[g][1]),
      .H2    (lane_h[g][2]),
      .H3    (lane_h[g][3]),
      .FULL  (lane_full[g])
    );
  end

  // The window is built from the pre-update history, so the lane mux sees
  // exactly what the lane shifts out of on this same edge.
  always_comb begin
    out_valid_d = 1'b0;
    priming_d   = 1'b0;
    ch_out_d    = ch_out_q;
    taps_d      = taps_q;
    if (accept) begin
      out_valid_d = lane_full[CH_IN];
      priming_d   = !lane_full[CH_IN];
      ch_out_d    = CH_IN;
      taps_d      = {lane_h[CH_IN][3], lane_h[CH_IN][2], lane_h[CH_IN][1],
                     lane_h[CH_IN][0], DATA_IN};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      priming_q   <= 1'b0;
      ch_out_q    <= '0;
      taps_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      priming_q   <= priming_d;
      ch_out_q    <= ch_out_d;
      taps_q      <= taps_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign PRIMING   = priming_q;
  assign CH_OUT    = ch_out_q;
  assign TAP1      = taps_q[0];
  assign TAP2      = taps_q[1];
  assign TAP3      = taps_q[2];
  assign TAP4      = taps_q[3];
  assign TAP5      = taps_q[4];
endmodule

// File: tb/tb_median5_window_buf.sv
// tb/tb_median5_window_buf.sv - randomized and directed bench for median5_window_buf
module tb_median5_window_buf;
  localparam int NCH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_all = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  ch_in = '0;
  logic [15:0] data_in = '0;
  logic        out_valid, priming;
  logic [3:0]  ch_out;
  logic [15:0] tap1, tap2, tap3, tap4, tap5;

  int total = 0;
  int bad = 0;

  median5_window_buf dut (
    .CLK(clk), .RST(rst), .CLR_ALL(clr_all), .IN_VALID(in_valid),
    .CH_IN(ch_in), .DATA_IN(data_in), .OUT_VALID(out_valid), .CH_OUT(ch_out),
    .TAP1(tap1), .TAP2(tap2), .TAP3(tap3), .TAP4(tap4), .TAP5(tap5),
    .PRIMING(priming)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] s16(input int v);
    return {16'b0, v[15:0]};
  endfunction

  // Reference: per channel, the samples accepted since the last flush, newest first.
  logic [15:0] hq [NCH][$];
  logic        e_valid = 1'b0, e_prim = 1'b0;
  logic [3:0]  e_ch = '0;
  logic [15:0] e_tap [5] = '{default: '0};

  always @(posedge clk) begin
    logic        v, cl, rs;
    int          c;
    logic [15:0] d;
    v = in_valid; cl = clr_all; rs = rst; c = int'(ch_in); d = data_in;
    if (rs || cl) begin
      for (int i = 0; i < NCH; i++) hq[i].delete();
      e_valid = 1'b0;
      e_prim  = 1'b0;
      if (rs) begin
        e_ch = '0;
        for (int k = 0; k < 5; k++) e_tap[k] = '0;
      end
    end else if (v && c < NCH) begin
      e_valid  = (hq[c].size() >= 4);
      e_prim   = !e_valid;
      e_ch     = 4'(c);
      e_tap[0] = d;
      for (int k = 1; k < 5; k++) e_tap[k] = (k - 1 < hq[c].size()) ? hq[c][k-1] : 16'h0;
      hq[c].push_front(d);
      if (hq[c].size() > 4) void'(hq[c].pop_back());
    end else begin
      e_valid = 1'b0;
      e_prim  = 1'b0;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    chk("priming", {31'b0, priming}, {31'b0, e_prim});
    chk("ch_out", {28'b0, ch_out}, {28'b0, e_ch});
    chk("tap1", {16'b0, tap1}, {16'b0, e_tap[0]});
    chk("tap2", {16'b0, tap2}, {16'b0, e_tap[1]});
    chk("tap3", {16'b0, tap3}, {16'b0, e_tap[2]});
    chk("tap4", {16'b0, tap4}, {16'b0, e_tap[3]});
    chk("tap5", {16'b0, tap5}, {16'b0, e_tap[4]});
  end

  task automatic drive(input logic v, input int ch, input int d,
                       input logic cl = 1'b0, input logic rs = 1'b0);
    @(negedge clk);
    in_valid = v; ch_in = 4'(ch); data_in = 16'(d); clr_all = cl; rst = rs;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic pin_taps(input string tag, input int a, input int b, input int c,
                          input int d, input int e);
    chk({tag, "_t1"}, {16'b0, tap1}, s16(a));
    chk({tag, "_t2"}, {16'b0, tap2}, s16(b));
    chk({tag, "_t3"}, {16'b0, tap3}, s16(c));
    chk({tag, "_t4"}, {16'b0, tap4}, s16(d));
    chk({tag, "_t5"}, {16'b0, tap5}, s16(e));
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ch", {28'b0, ch_out}, 32'd0);
    pin_taps("rst", 0, 0, 0, 0, 0);

    // 1: ch 3 primes on four samples, fifth yields a window
    for (int i = 1; i <= 5; i++) begin
      drive(1, 3, i * 10);
      settle();
      chk("t1_prim", {31'b0, priming}, (i < 5) ? 32'd1 : 32'd0);
    end
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_ch", {28'b0, ch_out}, 32'd3);
    pin_taps("t1", 50, 40, 30, 20, 10);

    // 2: round-robin over all channels
    drive(0, 0, 0, 1);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < NCH; c++) begin
        drive(1, c, c * 100 + r);
        settle();
        if (r < 4) chk("t2_novalid", {31'b0, out_valid}, 32'd0);
        if (c == 7 && r == 4) pin_taps("t2r4", 704, 703, 702, 701, 700);
        if (c == 7 && r == 5) pin_taps("t2r5", 705, 704, 703, 702, 701);
      end

    // 3: extreme signed values pass through bit-exact
    drive(0, 0, 0, 1);
    drive(1, 0, -32768); drive(1, 0, 32767); drive(1, 0, -1); drive(1, 0, 0); drive(1, 0, 1);
    settle();
    chk("t3_valid", {31'b0, out_valid}, 32'd1);
    pin_taps("t3", 1, 0, -1, 32767, -32768);

    // 4: flush wins over a simultaneous sample
    for (int i = 0; i < 5; i++) drive(1, 5, 900 + i);
    drive(1, 5, 999, 1);
    settle();
    chk("t4_clr_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_clr_prim", {31'b0, priming}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 5, i);
      settle();
      chk("t4_valid", {31'b0, out_valid}, (i == 5) ? 32'd1 : 32'd0);
    end
    pin_taps("t4", 5, 4, 3, 2, 1);

    // 5: reset mid-stream on a primed channel
    drive(1, 5, 77, 0, 1);
    settle();
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_tap1", {16'b0, tap1}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 5, 60 + i);
      settle();
      chk("t5_prim", {31'b0, priming}, (i < 5) ? 32'd1 : 32'd0);
    end
    pin_taps("t5", 65, 64, 63, 62, 61);

    // 6: sparse valid on ch 9, outputs hold between pulses
    for (int i = 1; i <= 7; i++) begin
      drive(1, 9, i * 3);
      drive(0, 2, 12345);
      drive(0, 4, 54321);
    end
    settle();
    chk("t6_ch", {28'b0, ch_out}, 32'd9);
    pin_taps("t6", 21, 18, 15, 12, 9);

    // random traffic with rare flushes and resets
    for (int n = 0; n < 3000; n++)
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)),
            int'($urandom_range(0, 65535)),
            $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
    drive(0, 0, 0);
    settle();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
